// File: rtl/arm_mem_stage_if.sv
// Memory-side bus of the ARM MEM stage.
// master: the pipeline stage that issues accesses.
// slave:  the data memory that answers them.
interface arm_mem_stage_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [LANES-1:0]  mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_req,
    output mem_we,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    input  mem_we,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/arm_mem_stage.sv
// ARM pipeline MEM stage: issues loads/stores on the memory bus, stalls the
// pipe until the memory answers, and registers the MEM/WB writeback bundle.
// Optional feature macro: ARM_MEM_FWD_EN adds combinational forwarding
// outputs (mem_fwd_valid, mem_fwd_reg, mem_fwd_data).
module arm_mem_stage (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          EXMEM_data_result,
  input  logic [31:0]          EXMEM_rd_data,
  input  logic                 EXMEM_rd_we,
  input  logic                 EXMEM_rd_data_sel,
  input  logic                 EXMEM_ld_byte_or_word,
  input  logic [3:0]           EXMEM_des_reg_num,
  input  logic [3:0]           EXMEM_mem_write_en,
  arm_mem_stage_if.master      mem,
  output logic                 mem_stall,
  output logic [31:0]          MEMWB_rd_data,
  output logic                 MEMWB_rd_we,
  output logic [3:0]           MEMWB_des_reg_num
`ifdef ARM_MEM_FWD_EN
  ,
  output logic                 mem_fwd_valid,
  output logic [3:0]           mem_fwd_reg,
  output logic [31:0]          mem_fwd_data
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;

  logic              is_load;
  logic              is_store;
  logic              access;
  logic              req;
  logic [BYTE_W-1:0] ld_byte;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wb_data;

  // Access decode, bus drive, stall and writeback data selection.
  always_comb begin
    is_load  = EXMEM_rd_we & EXMEM_rd_data_sel;
    is_store = |EXMEM_mem_write_en;
    access   = is_load | is_store;

    // Request stays up through WAIT; reset kills any outstanding access.
    req = rst_b & (access | (state == WAIT));

    mem.mem_req   = req;
    mem.mem_addr  = {EXMEM_data_result[DATA_W-1:2], 2'b00};
    mem.mem_we    = req ? EXMEM_mem_write_en : LANES'(0);
    mem.mem_wdata = EXMEM_ld_byte_or_word ? {LANES{EXMEM_rd_data[BYTE_W-1:0]}}
                                          : EXMEM_rd_data;

    mem_stall = access & ~mem.mem_ready;

    // Little-endian byte lane select, lane 0 in bits 7:0.
    case (EXMEM_data_result[1:0])
      2'd0:    ld_byte = mem.mem_rdata[7:0];
      2'd1:    ld_byte = mem.mem_rdata[15:8];
      2'd2:    ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_data = EXMEM_ld_byte_or_word ? DATA_W'(ld_byte) : mem.mem_rdata;
    wb_data = EXMEM_rd_data_sel ? ld_data : EXMEM_data_result;
  end

`ifdef ARM_MEM_FWD_EN
  // Forward the writeback value as soon as it is final (not while stalled).
  always_comb begin
    mem_fwd_valid = EXMEM_rd_we & ~mem_stall;
    mem_fwd_reg   = EXMEM_des_reg_num;
    mem_fwd_data  = wb_data;
  end
`endif

  // Access FSM and MEM/WB pipeline register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state             <= IDLE;
      MEMWB_rd_data     <= DATA_W'(0);
      MEMWB_rd_we       <= 1'b0;
      MEMWB_des_reg_num <= REG_W'(0);
    end else begin
      case (state)
        IDLE:    if (access && !mem.mem_ready) state <= WAIT;
        WAIT:    if (mem.mem_ready)            state <= IDLE;
        default:                               state <= IDLE;
      endcase

      if (!mem_stall) begin
        MEMWB_rd_data     <= wb_data;
        MEMWB_rd_we       <= EXMEM_rd_we;
        MEMWB_des_reg_num <= EXMEM_des_reg_num;
      end else begin
        MEMWB_rd_we       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arm_mem_stage.sv
// Self-checking bench for arm_mem_stage: scoreboard of expected MEM/WB
// bundles, a latency-programmable memory responder, and a reset-in-WAIT case.
module tb_arm_mem_stage;

  logic        clk;
  logic        rst_b;
  logic [31:0] EXMEM_data_result;
  logic [31:0] EXMEM_rd_data;
  logic        EXMEM_rd_we;
  logic        EXMEM_rd_data_sel;
  logic        EXMEM_ld_byte_or_word;
  logic [3:0]  EXMEM_des_reg_num;
  logic [3:0]  EXMEM_mem_write_en;
  logic        mem_stall;
  logic [31:0] MEMWB_rd_data;
  logic        MEMWB_rd_we;
  logic [3:0]  MEMWB_des_reg_num;
`ifdef ARM_MEM_FWD_EN
  logic        mem_fwd_valid;
  logic [3:0]  mem_fwd_reg;
  logic [31:0] mem_fwd_data;
`endif

  arm_mem_stage_if mem ();

  arm_mem_stage dut (
    .clk                   (clk),
    .rst_b                 (rst_b),
    .EXMEM_data_result     (EXMEM_data_result),
    .EXMEM_rd_data         (EXMEM_rd_data),
    .EXMEM_rd_we           (EXMEM_rd_we),
    .EXMEM_rd_data_sel     (EXMEM_rd_data_sel),
    .EXMEM_ld_byte_or_word (EXMEM_ld_byte_or_word),
    .EXMEM_des_reg_num     (EXMEM_des_reg_num),
    .EXMEM_mem_write_en    (EXMEM_mem_write_en),
    .mem                   (mem.master),
    .mem_stall             (mem_stall),
    .MEMWB_rd_data         (MEMWB_rd_data),
    .MEMWB_rd_we           (MEMWB_rd_we),
    .MEMWB_des_reg_num     (MEMWB_des_reg_num)
`ifdef ARM_MEM_FWD_EN
    ,
    .mem_fwd_valid         (mem_fwd_valid),
    .mem_fwd_reg           (mem_fwd_reg),
    .mem_fwd_data          (mem_fwd_data)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        we;
    logic [3:0]  rn;
  } wb_t;

  wb_t         sb_q[$];
  int          n_checks;
  int          n_errors;
  logic [31:0] last_data;
  logic [3:0]  last_reg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    EXMEM_data_result     = 32'h0;
    EXMEM_rd_data         = 32'h0;
    EXMEM_rd_we           = 1'b0;
    EXMEM_rd_data_sel     = 1'b0;
    EXMEM_ld_byte_or_word = 1'b0;
    EXMEM_des_reg_num     = 4'h0;
    EXMEM_mem_write_en    = 4'h0;
    mem.mem_ready         = 1'b0;
    mem.mem_rdata         = 32'h0;
  endtask

  // One instruction through MEM; called just after a rising edge.
  // lat = cycles of mem_ready low before completion; spur = ready pulse with no access.
  task automatic txn(input logic [31:0] res, input logic [31:0] rdd,
                     input logic we, input logic sel, input logic bsel,
                     input logic [3:0] rn, input logic [3:0] wen,
                     input int lat, input logic spur, input logic [31:0] rdata);
    logic        acc;
    int          cycles;
    logic        stall_e;
    logic [31:0] sh;
    logic [31:0] exp_wb;
    logic [31:0] exp_wd;
    wb_t         e;
    acc    = (we & sel) | (wen != 4'h0);
    cycles = acc ? lat : 0;
    sh     = rdata >> (8 * int'(res[1:0]));
    if (sel) exp_wb = bsel ? {24'h0, sh[7:0]} : rdata;
    else     exp_wb = res;
    exp_wd = bsel ? {rdd[7:0], rdd[7:0], rdd[7:0], rdd[7:0]} : rdd;
    sb_q.push_back('{data: exp_wb, we: we, rn: rn});

    EXMEM_data_result     = res;
    EXMEM_rd_data         = rdd;
    EXMEM_rd_we           = we;
    EXMEM_rd_data_sel     = sel;
    EXMEM_ld_byte_or_word = bsel;
    EXMEM_des_reg_num     = rn;
    EXMEM_mem_write_en    = wen;
    mem.mem_rdata         = rdata;

    for (int k = 0; k <= cycles; k++) begin
      mem.mem_ready = acc ? (k == cycles) : spur;
      stall_e = acc && (k < cycles);
      #1;
      check_val("mem_req", 32'(mem.mem_req), 32'(acc));
      check_val("mem_stall", 32'(mem_stall), 32'(stall_e));
      check_val("mem_we", 32'(mem.mem_we), acc ? 32'(wen) : 32'h0);
      if (acc) check_val("mem_addr", mem.mem_addr, {res[31:2], 2'b00});
      if (wen != 4'h0) check_val("mem_wdata", mem.mem_wdata, exp_wd);
`ifdef ARM_MEM_FWD_EN
      check_val("fwd_valid", 32'(mem_fwd_valid), 32'(we & ~stall_e));
      if (we && !stall_e) begin
        check_val("fwd_reg", 32'(mem_fwd_reg), 32'(rn));
        check_val("fwd_data", mem_fwd_data, exp_wb);
      end
`endif
      @(posedge clk);
      #1;
      if (k < cycles) begin
        check_val("bubble_we", 32'(MEMWB_rd_we), 32'h0);
        check_val("hold_data", MEMWB_rd_data, last_data);
        check_val("hold_reg", 32'(MEMWB_des_reg_num), 32'(last_reg));
      end
    end

    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check_val("wb_data", MEMWB_rd_data, e.data);
      check_val("wb_we", 32'(MEMWB_rd_we), 32'(e.we));
      check_val("wb_reg", 32'(MEMWB_des_reg_num), 32'(e.rn));
      last_data = e.data;
      last_reg  = e.rn;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_data = 32'h0;
    last_reg  = 4'h0;
    rst_b     = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_data", MEMWB_rd_data, 32'h0);
    check_val("rst_we", 32'(MEMWB_rd_we), 32'h0);
    check_val("rst_reg", 32'(MEMWB_des_reg_num), 32'h0);
    check_val("rst_req", 32'(mem.mem_req), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // res, rdd, we, sel, bsel, rn, wen, lat, spur, rdata
    txn(32'h1234_5678, 32'h0,         1'b1, 1'b0, 1'b0, 4'd3, 4'b0000, 0, 1'b0, 32'h0);
    txn(32'h0000_0100, 32'h0,         1'b1, 1'b1, 1'b0, 4'd1, 4'b0000, 0, 1'b0, 32'hDEAD_BEEF);
    txn(32'h0000_0103, 32'h0,         1'b1, 1'b1, 1'b1, 4'd5, 4'b0000, 3, 1'b0, 32'hAABB_CCDD);
    txn(32'h0000_0202, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 4'd0, 4'b0100, 1, 1'b0, 32'h0);
    txn(32'h0000_0300, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'd7, 4'b1111, 2, 1'b0, 32'h0);
    txn(32'h0000_0ABC, 32'h0,         1'b1, 1'b0, 1'b0, 4'd9, 4'b0000, 0, 1'b1, 32'hFFFF_FFFF);
    txn(32'h0000_0400, 32'h0,         1'b1, 1'b1, 1'b1, 4'd2, 4'b0000, 0, 1'b0, 32'h1122_3344);
    txn(32'h0000_0401, 32'h0,         1'b1, 1'b1, 1'b1, 4'd4, 4'b0000, 1, 1'b0, 32'h1122_3344);
    txn(32'h0000_0402, 32'h0,         1'b1, 1'b1, 1'b1, 4'd6, 4'b0000, 0, 1'b0, 32'h1122_3344);
    txn(32'h0000_0500, 32'h0,         1'b1, 1'b1, 1'b0, 4'd8, 4'b0000, 4, 1'b0, 32'h0BAD_F00D);
    txn(32'h0000_0604, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0011, 0, 1'b0, 32'h0);

    // Reset while an access is waiting on memory.
    EXMEM_data_result     = 32'h0000_0700;
    EXMEM_rd_data         = 32'h0000_00FF;
    EXMEM_rd_we           = 1'b1;
    EXMEM_rd_data_sel     = 1'b0;
    EXMEM_ld_byte_or_word = 1'b0;
    EXMEM_des_reg_num     = 4'd11;
    EXMEM_mem_write_en    = 4'b1111;
    mem.mem_ready         = 1'b0;
    @(posedge clk);
    #1;
    check_val("wait_req", 32'(mem.mem_req), 32'h1);
    #2;
    rst_b = 1'b0;
    #1;
    check_val("rstw_req", 32'(mem.mem_req), 32'h0);
    check_val("rstw_we", 32'(mem.mem_we), 32'h0);
    check_val("rstw_wbwe", 32'(MEMWB_rd_we), 32'h0);
    check_val("rstw_data", MEMWB_rd_data, 32'h0);
    idle_inputs();
    last_data = 32'h0;
    last_reg  = 4'h0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    txn(32'h0000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 4'd2, 4'b0000, 0, 1'b0, 32'h5566_7788);
    txn(32'h0000_0002, 32'h0,         1'b1, 1'b1, 1'b1, 4'd5, 4'b0000, 2, 1'b0, 32'h5566_7788);

    check_val("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arm_mem_stage.md
ARM_MEM_STAGE -- requirements
Module: arm_mem_stage

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_b  input  1  reset, asynchronous, active-low.
REQ-003 EXMEM_data_result  input  32  ALU result: memory address, or writeback value for non-loads.
REQ-004 EXMEM_rd_data  input  32  store data.
REQ-005 EXMEM_rd_we / EXMEM_rd_data_sel / EXMEM_ld_byte_or_word  input  1 each  reg write enable / 1=writeback from memory (load) / 1=byte, 0=word.
REQ-006 EXMEM_des_reg_num  input  4  destination register; EXMEM_mem_write_en  input  4  per-byte store lane enables.
REQ-007 mem_addr  output  32  word-aligned address {EXMEM_data_result[31:2],2'b00}.
REQ-008 mem_req / mem_we  output  1 / 4  access request / byte write enables; mem_wdata  output  32  store data.
REQ-009 mem_ready  input  1  memory completion; mem_rdata  input  32  load data, valid when mem_ready=1.
REQ-010 mem_stall  output  1  upstream must hold EXMEM_* and PC stable while high.
REQ-011 MEMWB_rd_data  output  32; MEMWB_rd_we  output  1; MEMWB_des_reg_num  output  4  registered writeback bundle.

Function
REQ-012 Access: load = EXMEM_rd_we & EXMEM_rd_data_sel; store = |EXMEM_mem_write_en; access = load | store.
REQ-013 FSM states IDLE and WAIT; reset state IDLE.
REQ-014 IDLE: if access, mem_req=1 combinationally; mem_ready=1 same cycle -> complete (stay IDLE); else -> WAIT.
REQ-015 WAIT: mem_req=1 held, address/data/enables unchanged; mem_ready=1 -> complete, -> IDLE; else stay WAIT (no timeout).
REQ-016 mem_stall = access & ~mem_ready, in either state (combinational).
REQ-017 mem_we = EXMEM_mem_write_en while mem_req=1, else 4'b0000; never nonzero for a load.
REQ-018 mem_wdata: word -> EXMEM_rd_data; byte -> EXMEM_rd_data[7:0] replicated to all four lanes.
REQ-019 Load extraction, little-endian: word -> mem_rdata; byte -> mem_rdata lane EXMEM_data_result[1:0] (lane 0 = bits 7:0), zero-extended.
REQ-020 Writeback data: rd_data_sel=1 -> extracted load data; 0 -> EXMEM_data_result.
REQ-021 Each cycle mem_stall=0: MEMWB_* <= {writeback data, EXMEM_rd_we, EXMEM_des_reg_num}; non-access latency 1 cycle.
REQ-022 Each cycle mem_stall=1: MEMWB_rd_we <= 0 (bubble); MEMWB_rd_data, MEMWB_des_reg_num hold.
REQ-023 Store completing: MEMWB_rd_we <= EXMEM_rd_we (writeback allowed, e.g. base update).
REQ-024 Back-to-back accesses: completion in IDLE or WAIT with next access present next cycle -> new mem_req issued that cycle, no idle gap.
REQ-025 mem_ready while mem_req=0 is ignored; no state or output change.

Reset
REQ-026 rst_b=0 asynchronously: state IDLE, MEMWB_rd_data=0, MEMWB_rd_we=0, MEMWB_des_reg_num=0.
REQ-027 Reset mid-WAIT: outstanding access abandoned; mem_req, mem_we drop with reset; no MEMWB write of it.
REQ-028 First rising edge after rst_b deasserts: normal operation from IDLE.

Configuration
REQ-029 Macro ARM_MEM_FWD_EN defined: add outputs mem_fwd_valid (1), mem_fwd_reg (4), mem_fwd_data (32), combinational, = {EXMEM_rd_we & ~mem_stall, EXMEM_des_reg_num, writeback data per REQ-020}.
REQ-030 ARM_MEM_FWD_EN undefined: these ports absent; all other behaviour identical.

Verification
REQ-031 ALU op: data_result=0x1234_5678, rd_we=1, sel=0, reg=3, write_en=0 -> mem_req=0; next cycle MEMWB = {0x12345678,1,3}.
REQ-032 Word load, ready same cycle: addr 0x100, mem_rdata=0xDEAD_BEEF -> mem_addr=0x100, stall=0; next cycle MEMWB_rd_data=0xDEADBEEF.
REQ-033 Byte load, addr 0x103, ready after 3 cycles, mem_rdata=0xAABB_CCDD -> stall high 3 cycles, MEMWB_rd_we=0 during; then MEMWB_rd_data=0x0000_00AA.
REQ-034 Byte store, rd_data=0x0000_0042, write_en=4'b0100, addr 0x202 -> mem_addr=0x200, mem_we=4'b0100, mem_wdata=0x4242_4242.
REQ-035 Reset asserted in WAIT -> mem_req=0, MEMWB_rd_we=0 immediately; after release, unstalled load to 0x0 completes normally.
REQ-036 With ARM_MEM_FWD_EN: stalled load to reg 5 -> mem_fwd_valid=0 until mem_ready, then 1 with mem_fwd_reg=5 and loaded data.
